// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_packer_if.sv
// Bus bundle for the OCI DCT packer: trace-entry input, packed-word output and end-of-test status.
// Both the entry and word channels transfer on a rising clk when valid & ready; a producer that
// raises valid holds it and its payload stable until ready, and ready never depends on valid.
interface nios_system_checkers_nios2_qsys_0_oci_dct_packer_if #(
    parameter int ENTRY_W = 2,
    parameter int ENTRIES = 15,
    parameter int CNT_W   = 4,
    parameter int DROP_W  = 16
);
    logic                         in_valid;
    logic [ENTRY_W-1:0]           in_data;
    logic                         in_ready;
    logic                         test_ending;
    logic                         dct_valid;
    logic                         dct_ready;
    logic [ENTRY_W*ENTRIES-1:0]   dct_buffer;
    logic [CNT_W-1:0]             dct_count;
    logic                         test_has_ended;
    logic [DROP_W-1:0]            drop_count;

    modport slave (
        input  in_valid, in_data, test_ending, dct_ready,
        output in_ready, dct_valid, dct_buffer, dct_count, test_has_ended, drop_count
    );

    modport master (
        output in_valid, in_data, test_ending, dct_ready,
        input  in_ready, dct_valid, dct_buffer, dct_count, test_has_ended, drop_count
    );
endinterface

// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_packer.sv
// Packs narrow OCI trace entries into wide words, flushes on test_ending and reports end of test.
// Optional dropped-entry counter is enabled by defining OCI_DCT_DROP_CNT_EN.
module nios_system_checkers_nios2_qsys_0_oci_dct_packer #(
    parameter int ENTRY_W = 2,
    parameter int ENTRIES = 15,
    parameter int CNT_W   = 4,
    parameter int DROP_W  = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    nios_system_checkers_nios2_qsys_0_oci_dct_packer_if.slave bus,
    output logic [1:0]                                 dbg_state
);
    localparam int W = ENTRY_W * ENTRIES;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [W-1:0]     fill_buf;
    logic [CNT_W-1:0] fill_cnt;
    logic [W-1:0]     acc_buf;
    logic [CNT_W-1:0] acc_cnt;
    logic             in_ready_w;
    logic             accept;
    logic             out_free;
    logic             load;

    logic             dct_valid_q;
    logic [W-1:0]     dct_buffer_q;
    logic [CNT_W-1:0] dct_count_q;

    assign in_ready_w = (state == ST_FILL) && (fill_cnt != FULL_CNT);
    assign accept     = bus.in_valid && in_ready_w;
    // Output slot may be reloaded in the same cycle the sink takes the current word.
    assign out_free   = !dct_valid_q || bus.dct_ready;

    // Fill contents as they will stand after this cycle's accept.
    always_comb begin
        acc_buf = fill_buf;
        acc_cnt = fill_cnt;
        if (accept) begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (fill_cnt == CNT_W'(k)) begin
                    acc_buf[k*ENTRY_W +: ENTRY_W] = bus.in_data;
                end
            end
            acc_cnt = fill_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        load = 1'b0;
        case (state)
            ST_FILL:  load = out_free && (acc_cnt == FULL_CNT);
            ST_FLUSH: load = out_free && (acc_cnt != '0);
            default:  load = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (bus.test_ending) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // An empty fill register emits nothing; skip DRAIN if the output is already free.
                if (load)                 state_nxt = ST_DRAIN;
                else if (fill_cnt == '0)  state_nxt = out_free ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_free) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_FILL;
            fill_buf     <= '0;
            fill_cnt     <= '0;
            dct_valid_q  <= 1'b0;
            dct_buffer_q <= '0;
            dct_count_q  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                fill_buf     <= '0;
                fill_cnt     <= '0;
                dct_valid_q  <= 1'b1;
                dct_buffer_q <= acc_buf;
                dct_count_q  <= acc_cnt;
            end else begin
                fill_buf <= acc_buf;
                fill_cnt <= acc_cnt;
                if (bus.dct_ready) dct_valid_q <= 1'b0;
            end
        end
    end

`ifdef OCI_DCT_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if ((state == ST_FILL) && bus.in_valid && !in_ready_w && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = {DROP_W{1'b0}};
`endif

    assign bus.in_ready       = in_ready_w;
    assign bus.dct_valid      = dct_valid_q;
    assign bus.dct_buffer     = dct_buffer_q;
    assign bus.dct_count      = dct_count_q;
    assign bus.test_has_ended = (state == ST_DONE);
    assign dbg_state          = state;
endmodule

// File: tb/tb_nios_system_checkers_nios2_qsys_0_oci_dct_packer.sv
// Directed and randomized bench for the OCI DCT packer with an entry-list reference model.
module tb_nios_system_checkers_nios2_qsys_0_oci_dct_packer;
    localparam int ENTRY_W = 2;
    localparam int ENTRIES = 15;
    localparam int CNT_W   = 4;
    localparam int DROP_W  = 16;
    localparam int W       = ENTRY_W * ENTRIES;
    localparam int EW      = CNT_W + W;

    logic clk;
    logic reset;
    logic [1:0] dbg_state;

    int checks;
    int failures;
    int exp_drop;

    logic [EW-1:0]      exp_q[$];
    logic [ENTRY_W-1:0] part_q[$];

    nios_system_checkers_nios2_qsys_0_oci_dct_packer_if #(
        .ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .DROP_W(DROP_W)
    ) bus ();

    nios_system_checkers_nios2_qsys_0_oci_dct_packer #(
        .ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: word = entry k shifted to k*ENTRY_W, tagged with its entry count.
    task automatic model_emit();
        logic [W-1:0] word;
        word = '0;
        foreach (part_q[k]) word = word | (W'(part_q[k]) << (ENTRY_W * k));
        exp_q.push_back({CNT_W'(part_q.size()), word});
        part_q.delete();
    endtask

    task automatic model_accept(input logic [ENTRY_W-1:0] d);
        part_q.push_back(d);
        if (part_q.size() == ENTRIES) model_emit();
    endtask

    task automatic model_flush();
        if (part_q.size() != 0) model_emit();
    endtask

    task automatic push_entry(input logic [ENTRY_W-1:0] d);
        check("in_ready_before_push", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        model_accept(d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_words_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.test_ending = 1'b0;
        bus.dct_ready   = 1'b0;
        exp_q.delete();
        part_q.delete();
        exp_drop = 0;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_dct_valid", 64'(bus.dct_valid), 64'd0);
        check("rst_dct_buffer", 64'(bus.dct_buffer), 64'd0);
        check("rst_dct_count", 64'(bus.dct_count), 64'd0);
        check("rst_ended", 64'(bus.test_has_ended), 64'd0);
        check("rst_drop", 64'(bus.drop_count), 64'd0);
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard: every consumed word must be the oldest expected word.
    always @(negedge clk) begin
        if (!reset && bus.dct_valid && bus.dct_ready) begin
            logic [EW-1:0] got;
            logic [EW-1:0] exp_w;
            got   = {bus.dct_count, bus.dct_buffer};
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : {EW{1'bx}};
            checks++;
            assert (got === exp_w) else begin
                failures++;
                $error("FAIL word observed=%0h expected=%0h", got, exp_w);
            end
        end
    end

    initial begin
        logic [ENTRY_W-1:0] d;
        bit v;
        bit exp_rdy;
        checks   = 0;
        failures = 0;

        // Full word, back-to-back, sink always ready.
        do_reset();
        bus.dct_ready = 1'b1;
        for (int k = 0; k < ENTRIES - 1; k++) push_entry(ENTRY_W'(k % 4));
        check("t1_valid_before_last", 64'(bus.dct_valid), 64'd0);
        push_entry(ENTRY_W'((ENTRIES - 1) % 4));
        check("t1_valid_latency", 64'(bus.dct_valid), 64'd1);
        check("t1_count", 64'(bus.dct_count), 64'd15);
        check("t1_buffer", 64'(bus.dct_buffer), 64'h24E4E4E4);
        check("t1_no_bubble", 64'(bus.in_ready), 64'd1);
        wait_drain(5);

        // Two words with the sink stalled.
        do_reset();
        bus.dct_ready = 1'b0;
        for (int k = 0; k < 2 * ENTRIES; k++) push_entry(ENTRY_W'($urandom));
        check("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
        check("t2_valid_held", 64'(bus.dct_valid), 64'd1);
        bus.dct_ready = 1'b1;
        wait_drain(10);
        check("t2_in_ready_after", 64'(bus.in_ready), 64'd1);

        // Partial flush and end-of-test timing.
        do_reset();
        bus.dct_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_entry(2'b11);
        bus.test_ending = 1'b1;
        tick();
        bus.test_ending = 1'b0;
        model_flush();
        check("t3_in_ready_flush", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 10 && !bus.dct_valid; i++) tick();
        check("t3_valid_seen", 64'(bus.dct_valid), 64'd1);
        check("t3_buffer", 64'(bus.dct_buffer), 64'h3FF);
        check("t3_ended_early", 64'(bus.test_has_ended), 64'd0);
        tick();
        check("t3_ended", 64'(bus.test_has_ended), 64'd1);
        check("t3_valid_gone", 64'(bus.dct_valid), 64'd0);
        check("t3_words_left", 64'(exp_q.size()), 64'd0);

        // Flush with nothing buffered.
        do_reset();
        bus.dct_ready   = 1'b1;
        bus.test_ending = 1'b1;
        tick();
        bus.test_ending = 1'b0;
        tick();
        check("t4_ended", 64'(bus.test_has_ended), 64'd1);
        check("t4_no_valid", 64'(bus.dct_valid), 64'd0);
        check("t4_in_ready", 64'(bus.in_ready), 64'd0);
        bus.test_ending = 1'b1;
        bus.in_valid    = 1'b1;
        repeat (3) tick();
        bus.test_ending = 1'b0;
        bus.in_valid    = 1'b0;
        check("t4_ended_sticky", 64'(bus.test_has_ended), 64'd1);
        check("t4_no_valid_late", 64'(bus.dct_valid), 64'd0);

        // Drops while fill is full and the sink is stalled.
        do_reset();
        bus.dct_ready = 1'b0;
        for (int k = 0; k < 2 * ENTRIES; k++) push_entry(ENTRY_W'($urandom));
        bus.in_valid = 1'b1;
        repeat (10) tick();
        bus.in_valid = 1'b0;
`ifdef OCI_DCT_DROP_CNT_EN
        check("t5_drop", 64'(bus.drop_count), 64'd10);
`else
        check("t5_drop", 64'(bus.drop_count), 64'd0);
`endif
        bus.dct_ready = 1'b1;
        wait_drain(10);

        // Asynchronous reset with a word pending and a partial fill.
        do_reset();
        bus.dct_ready = 1'b0;
        for (int k = 0; k < ENTRIES + 7; k++) push_entry(ENTRY_W'($urandom));
        check("t6_valid_before", 64'(bus.dct_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 64'(bus.dct_valid), 64'd0);
        check("t6_async_buffer", 64'(bus.dct_buffer), 64'd0);
        check("t6_async_count", 64'(bus.dct_count), 64'd0);
        exp_q.delete();
        part_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);
        bus.dct_ready = 1'b1;
        repeat (20) tick();
        check("t6_no_stale", 64'(bus.dct_valid), 64'd0);

        // Randomized traffic with random sink back-pressure, then final flush.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            exp_rdy = (exp_q.size() < 2);
            check("rand_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            bus.dct_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if (i % 50 < 12) bus.dct_ready = 1'b0;
            v = ($urandom_range(0, 2) != 0);
            d = ENTRY_W'($urandom);
            bus.in_valid = v;
            bus.in_data  = d;
            if (v && exp_rdy) model_accept(d);
            else if (v) exp_drop++;
            tick();
            bus.in_valid = 1'b0;
        end
        bus.dct_ready   = 1'b1;
        exp_rdy = (exp_q.size() < 2);
        d = ENTRY_W'($urandom);
        bus.in_valid    = exp_rdy;
        bus.in_data     = d;
        bus.test_ending = 1'b1;
        if (exp_rdy) model_accept(d);
        tick();
        bus.in_valid    = 1'b0;
        bus.test_ending = 1'b0;
        model_flush();
        wait_drain(20);
        tick();
        tick();
        check("rand_ended", 64'(bus.test_has_ended), 64'd1);
`ifdef OCI_DCT_DROP_CNT_EN
        check("rand_drop", 64'(bus.drop_count), 64'(exp_drop));
`else
        check("rand_drop", 64'(bus.drop_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
